// File: rtl/key_debounce.sv
// key_debounce
//   Turns a raw, bouncing push-button into clean single-cycle step events for
//   the LED counter stage. The key is synchronised into CLOCK_50, debounced by
//   a restart-on-bounce stability counter, and edge-detected. While the key is
//   held, an auto-repeat FSM emits repeat pulses.
//
// Ports
//   CLOCK_50      in   system clock (50 MHz)
//   RST           in   asynchronous, active-high reset
//   key_in        in   raw button level, asynchronous to CLOCK_50
//   key_level     out  debounced level, 1 = pressed
//   press_pulse   out  one-cycle pulse on an accepted press
//   release_pulse out  one-cycle pulse on an accepted release
//   repeat_pulse  out  one-cycle pulse per auto-repeat while held
//   step_pulse    out  press_pulse | repeat_pulse (downstream increment enable)
module key_debounce #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic CLOCK_50,
  input  logic RST,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  // Raw level of a released key; the synchroniser resets to it so that
  // leaving reset with the key up never looks like a press.
  localparam logic KEY_IDLE = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    REPEATING
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             key_level_q, key_level_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic             step_q, step_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  state_t           state_q, state_d;

  logic key_pressed;
  logic differ;
  logic accept_press;
  logic accept_release;

  // Synchroniser and debounce filter.
  always_comb begin
    sync1_d     = key_in;
    sync2_d     = sync1_q;
    key_pressed = KEY_IDLE ? ~sync2_q : sync2_q;
    differ      = (key_pressed != key_level_q);

    key_level_d = key_level_q;
    db_cnt_d    = '0;
    if (differ) begin
      if (db_cnt_q == DB_LAST) begin
        key_level_d = key_pressed;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    accept_press   = differ && (db_cnt_q == DB_LAST) && key_pressed;
    accept_release = differ && (db_cnt_q == DB_LAST) && !key_pressed;
  end

  // Auto-repeat FSM and pulse generation.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    repeat_d  = 1'b0;

    case (state_q)
      IDLE: begin
        rpt_cnt_d = '0;
        if (accept_press) begin
          state_d = ARMING;
        end
      end
      ARMING: begin
        // A release takes priority over a coincident repeat expiry.
        if (accept_release) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == DELAY_LAST) begin
          repeat_d  = 1'b1;
          rpt_cnt_d = '0;
          state_d   = REPEATING;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      REPEATING: begin
        if (accept_release) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == PERIOD_LAST) begin
          repeat_d  = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
      end
    endcase

    press_d   = accept_press;
    release_d = accept_release;
    // Press is only accepted from IDLE and repeats only occur outside IDLE,
    // so the two sources never coincide.
    step_d    = accept_press | repeat_d;
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sync1_q     <= KEY_IDLE;
      sync2_q     <= KEY_IDLE;
      key_level_q <= 1'b0;
      db_cnt_q    <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
      step_q      <= 1'b0;
      rpt_cnt_q   <= '0;
      state_q     <= IDLE;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      key_level_q <= key_level_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      step_q      <= step_d;
      rpt_cnt_q   <= rpt_cnt_d;
      state_q     <= state_d;
    end
  end

  assign key_level     = key_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign step_pulse    = step_q;

endmodule
